ball_motion_ctrl: RTL and testbench
===================================

// Module: ball_motion_ctrl
// PURPOSE
//   Frame-rate ball position generator for the breakout display path.
//   Runs in the 100 MHz clock domain and watches the sync generator's pixelX/pixelY.
//   Once per frame it moves the ball and reflects it off the walls and the paddle.
//   ballX/ballY feed the ball-object renderer, which draws the square at that position.
// PARAMETERS
//   H_ACTIVE     640  visible pixels per line
//   V_ACTIVE     480  visible lines per frame
//   BALL_SIZE    8    ball edge length, px (power of 2)
//   PADDLE_Y     450  paddle top line, px
//   PADDLE_W     64   paddle width, px
//   BALL_VEL     2    per-frame step per axis, px (1..7)
//   MISS_FRAMES  60   frames held in MISS before re-serve
//   MAX_VEL      6    velocity ceiling (SPEED_RAMP_EN only)
// PORTS
//   clock       in   1   system clock, 100 MHz
//   reset       in   1   async, active-low; asserting it forces the reset state immediately
//   pixelX      in   10  current pixel column from the sync generator
//   pixelY      in   10  current pixel line from the sync generator
//   paddleX     in   10  paddle left edge, 0..H_ACTIVE-PADDLE_W
//   launch      in   1   serve request; level input, rising edge detected internally
//   ballX       out  10  ball left edge, registered
//   ballY       out  10  ball top edge, registered
//   ballActive  out  1   1 while in MOVING
//   paddleHit   out  1   1-clock pulse on a paddle reflection
//   wallHit     out  1   1-clock pulse on a left, right or top reflection
//   miss        out  1   1-clock pulse when the ball reaches the bottom
//   state       out  2   0=SERVE 1=MOVING 2=MISS
// BEHAVIOUR
//   Reset values:
//     state=SERVE; ballX=H_ACTIVE/2-BALL_SIZE/2 (316); ballY=PADDLE_Y-BALL_SIZE (442).
//     dirX=right, dirY=up, vel=BALL_VEL, all pulses 0, miss counter 0, edge-detect registers 0.
//   Frame tick (tick):
//     1-clock pulse on the first clock where pixelY==V_ACTIVE+1 && pixelX==0.
//     Produced by edge detection, because each pixel coordinate is held for 4 clocks.
//     All position, state and counter updates happen only on tick; outputs update 1 clock after tick.
//   Launch:
//     Rising edge of launch is latched into a pending flag.
//     The flag is consumed on the next tick, only in SERVE.
//     In any other state the edge is discarded.
//   SERVE:
//     Each tick: ballX=paddleX+PADDLE_W/2-BALL_SIZE/2, ballY=PADDLE_Y-BALL_SIZE.
//     Pending launch -> MOVING with dirX=right, dirY=up, on that same tick.
//   MOVING:
//     Each tick, step each axis by vel in its current direction, with clamp/reflect:
//     - right: if ballX+vel >= H_ACTIVE-BALL_SIZE: ballX=H_ACTIVE-BALL_SIZE, dirX=left, wallHit.
//     - left:  if ballX <= vel: ballX=0, dirX=right, wallHit.
//     - up:    if ballY <= vel: ballY=0, dirY=down, wallHit.
//     - down, paddle:
//         condition: ballY+BALL_SIZE <= PADDLE_Y and ballY+BALL_SIZE+vel >= PADDLE_Y,
//                    and ballX+BALL_SIZE > paddleX and ballX < paddleX+PADDLE_W.
//         action: ballY=PADDLE_Y-BALL_SIZE, dirY=up, paddleHit.
//     - down, bottom: if not a paddle reflection and ballY+vel >= V_ACTIVE-BALL_SIZE:
//         ballY=V_ACTIVE-BALL_SIZE, miss, go to MISS.
//     Both axes are evaluated in the same tick, so a corner hit reflects both.
//     wallHit and paddleHit may assert together. Paddle has priority over bottom.
//   MISS:
//     Ball is frozen. Counter increments each tick.
//     At MISS_FRAMES-1: counter=0 and go to SERVE.
//   Arithmetic:
//     Compares are 11-bit unsigned, so there is no wrap.
//     ballX stays in 0..H_ACTIVE-BALL_SIZE and ballY in 0..V_ACTIVE-BALL_SIZE at all times.
//   Reset mid-frame or mid-MISS: immediate return to the reset values. No tick is generated by the reset.
// CONFIGURATION
//   SPEED_RAMP_EN defined:
//     Every 4th paddleHit increments vel by 1, saturating at MAX_VEL.
//     vel returns to BALL_VEL on entry to SERVE.
//   SPEED_RAMP_EN undefined: vel is constant BALL_VEL and there is no hit counter.
// TESTING
//   - Reset, paddleX=100, 2 frames -> state=0, ballX=128, ballY=442, all pulses 0.
//   - launch pulse in SERVE -> next tick state=1; following tick ballX=130, ballY=440.
//   - MOVING right at ballX=631 -> tick: ballX=632, dirX=left, one wallHit; next tick ballX=630.
//   - Down at ballY=441, paddleX=ballX-10 -> ballY=442, dirY=up, one paddleHit.
//     Same approach with paddleX=ballX+20 -> ballY climbs to 472, then miss, state=2.
//   - MISS -> exactly 60 ticks later state=0; launch pulse during MISS is ignored.
//   - SPEED_RAMP_EN: 8 paddle hits -> vel=4; a miss, then re-serve -> vel=2.

Source files
------------

// File: rtl/ball_motion_ctrl.sv
// Frame-rate ball motion controller: serves, moves and reflects the ball once per frame.
// Optional velocity ramp on paddle hits is enabled with `define SPEED_RAMP_EN.
module ball_motion_ctrl #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned BALL_SIZE   = 8,
    parameter int unsigned PADDLE_Y    = 450,
    parameter int unsigned PADDLE_W    = 64,
    parameter int unsigned BALL_VEL    = 2,
    parameter int unsigned MISS_FRAMES = 60,
    parameter int unsigned MAX_VEL     = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] pixelX,
    input  logic [9:0] pixelY,
    input  logic [9:0] paddleX,
    input  logic       launch,
    output logic [9:0] ballX,
    output logic [9:0] ballY,
    output logic       ballActive,
    output logic       paddleHit,
    output logic       wallHit,
    output logic       miss,
    output logic [1:0] state
);

    localparam int unsigned CNT_W = $clog2(MISS_FRAMES);

    localparam logic [10:0] X_MAX     = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_MAX     = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] PAD_LINE  = 11'(PADDLE_Y);
    localparam logic [10:0] BALL_EXT  = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_WIDTH = 11'(PADDLE_W);
    localparam logic [9:0]  X_RESET   = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  Y_SERVE   = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0]  X_OFFSET  = 10'(PADDLE_W / 2 - BALL_SIZE / 2);

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        MOVING = 2'd1,
        MISS   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [9:0]       ballX_q, ballX_d;
    logic [9:0]       ballY_q, ballY_d;
    logic             dirRight_q, dirRight_d;
    logic             dirDown_q, dirDown_d;
    logic [CNT_W-1:0] missCnt_q, missCnt_d;
    logic             frameCond_q, launch_q, pending_q, pending_d;
    logic             paddleHit_q, paddleHit_d;
    logic             wallHit_q, wallHit_d;
    logic             miss_q, miss_d;
    logic [2:0]       vel;

`ifdef SPEED_RAMP_EN
    logic [2:0] vel_q, vel_d;
    logic [1:0] hitCnt_q, hitCnt_d;
    assign vel = vel_q;
`else
    assign vel = 3'(BALL_VEL);
`endif

    logic        frameCond, tick, launchRise, padOverlap;
    logic [10:0] xw, yw, pw, vw;

    // Each pixel coordinate lasts several clocks, so the frame tick is the rising edge of the match.
    assign frameCond  = (pixelY == 10'(V_ACTIVE + 1)) && (pixelX == 10'd0);
    assign tick       = frameCond && !frameCond_q;
    assign launchRise = launch && !launch_q;

    assign xw = {1'b0, ballX_q};
    assign yw = {1'b0, ballY_q};
    assign pw = {1'b0, paddleX};
    assign vw = {8'd0, vel};
    assign padOverlap = (xw + BALL_EXT > pw) && (xw < pw + PAD_WIDTH);

    always_comb begin
        state_d     = state_q;
        ballX_d     = ballX_q;
        ballY_d     = ballY_q;
        dirRight_d  = dirRight_q;
        dirDown_d   = dirDown_q;
        missCnt_d   = missCnt_q;
        pending_d   = pending_q;
        paddleHit_d = 1'b0;
        wallHit_d   = 1'b0;
        miss_d      = 1'b0;
`ifdef SPEED_RAMP_EN
        vel_d       = vel_q;
        hitCnt_d    = hitCnt_q;
`endif

        // A launch edge is only remembered while serving; elsewhere it is dropped.
        if (state_q != SERVE) begin
            pending_d = 1'b0;
        end else begin
            if (tick && pending_q) pending_d = 1'b0;
            if (launchRise)        pending_d = 1'b1;
        end

        if (tick) begin
            case (state_q)
                SERVE: begin
                    ballX_d = paddleX + X_OFFSET;
                    ballY_d = Y_SERVE;
                    if (pending_q) begin
                        state_d    = MOVING;
                        dirRight_d = 1'b1;
                        dirDown_d  = 1'b0;
                    end
                end
                MOVING: begin
                    if (dirRight_q) begin
                        if (xw + vw >= X_MAX) begin
                            ballX_d    = X_MAX[9:0];
                            dirRight_d = 1'b0;
                            wallHit_d  = 1'b1;
                        end else begin
                            ballX_d = ballX_q + 10'(vel);
                        end
                    end else begin
                        if (xw <= vw) begin
                            ballX_d    = 10'd0;
                            dirRight_d = 1'b1;
                            wallHit_d  = 1'b1;
                        end else begin
                            ballX_d = ballX_q - 10'(vel);
                        end
                    end

                    // Paddle check runs before the bottom check so a catch wins over a miss.
                    if (!dirDown_q) begin
                        if (yw <= vw) begin
                            ballY_d   = 10'd0;
                            dirDown_d = 1'b1;
                            wallHit_d = 1'b1;
                        end else begin
                            ballY_d = ballY_q - 10'(vel);
                        end
                    end else if ((yw + BALL_EXT <= PAD_LINE) &&
                                 (yw + BALL_EXT + vw >= PAD_LINE) && padOverlap) begin
                        ballY_d     = Y_SERVE;
                        dirDown_d   = 1'b0;
                        paddleHit_d = 1'b1;
`ifdef SPEED_RAMP_EN
                        hitCnt_d = hitCnt_q + 2'd1;
                        if (hitCnt_q == 2'd3 && vel_q < 3'(MAX_VEL)) vel_d = vel_q + 3'd1;
`endif
                    end else if (yw + vw >= Y_MAX) begin
                        ballY_d   = Y_MAX[9:0];
                        miss_d    = 1'b1;
                        missCnt_d = '0;
                        state_d   = MISS;
                    end else begin
                        ballY_d = ballY_q + 10'(vel);
                    end
                end
                MISS: begin
                    if (missCnt_q == CNT_W'(MISS_FRAMES - 1)) begin
                        missCnt_d = '0;
                        state_d   = SERVE;
`ifdef SPEED_RAMP_EN
                        vel_d    = 3'(BALL_VEL);
                        hitCnt_d = 2'd0;
`endif
                    end else begin
                        missCnt_d = missCnt_q + CNT_W'(1);
                    end
                end
                default: state_d = SERVE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= SERVE;
            ballX_q     <= X_RESET;
            ballY_q     <= Y_SERVE;
            dirRight_q  <= 1'b1;
            dirDown_q   <= 1'b0;
            missCnt_q   <= '0;
            frameCond_q <= 1'b0;
            launch_q    <= 1'b0;
            pending_q   <= 1'b0;
            paddleHit_q <= 1'b0;
            wallHit_q   <= 1'b0;
            miss_q      <= 1'b0;
`ifdef SPEED_RAMP_EN
            vel_q       <= 3'(BALL_VEL);
            hitCnt_q    <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            ballX_q     <= ballX_d;
            ballY_q     <= ballY_d;
            dirRight_q  <= dirRight_d;
            dirDown_q   <= dirDown_d;
            missCnt_q   <= missCnt_d;
            frameCond_q <= frameCond;
            launch_q    <= launch;
            pending_q   <= pending_d;
            paddleHit_q <= paddleHit_d;
            wallHit_q   <= wallHit_d;
            miss_q      <= miss_d;
`ifdef SPEED_RAMP_EN
            vel_q       <= vel_d;
            hitCnt_q    <= hitCnt_d;
`endif
        end
    end

    assign ballX      = ballX_q;
    assign ballY      = ballY_q;
    assign state      = state_q;
    assign ballActive = (state_q == MOVING);
    assign paddleHit  = paddleHit_q;
    assign wallHit    = wallHit_q;
    assign miss       = miss_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Randomized bench for ball_motion_ctrl, checked against a frame-level ball model.
module tb_ball_motion_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] pixelX = 10'd0;
    logic [9:0] pixelY = 10'd0;
    logic [9:0] paddleX = 10'd100;
    logic       launch = 1'b0;
    logic [9:0] ballX, ballY;
    logic       ballActive, paddleHit, wallHit, miss;
    logic [1:0] state;

    int checks = 0;
    int passes = 0;
    int frameNo = 0;

    // Reference model: ball state at frame granularity, plain signed arithmetic.
    int mState, mX, mY, mVel, mHits, mCnt;
    bit mRight, mDown, mPend;
    int ePulse;

    ball_motion_ctrl dut (
        .clock(clock), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
        .paddleX(paddleX), .launch(launch), .ballX(ballX), .ballY(ballY),
        .ballActive(ballActive), .paddleHit(paddleHit), .wallHit(wallHit),
        .miss(miss), .state(state)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    task automatic modelReset();
        mState = 0; mX = 316; mY = 442; mRight = 1; mDown = 0;
        mVel = 2; mHits = 0; mCnt = 0; mPend = 0; ePulse = 0;
    endtask

    task automatic modelStep(input int pad);
        int nx, ny;
        bit wall, padHit, missed;
        wall = 0; padHit = 0; missed = 0;
        case (mState)
            0: begin
                mX = pad + 28;
                mY = 442;
                if (mPend) begin
                    mState = 1; mRight = 1; mDown = 0; mPend = 0;
                end
            end
            1: begin
                nx = mRight ? mX + mVel : mX - mVel;
                if (nx >= 632)   begin nx = 632; mRight = 0; wall = 1; end
                else if (nx <= 0) begin nx = 0;   mRight = 1; wall = 1; end
                if (!mDown) begin
                    ny = mY - mVel;
                    if (ny <= 0) begin ny = 0; mDown = 1; wall = 1; end
                end else if (mY + 8 <= 450 && mY + 8 + mVel >= 450 &&
                             mX + 8 > pad && mX < pad + 64) begin
                    ny = 442; mDown = 0; padHit = 1;
                    mHits++;
`ifdef SPEED_RAMP_EN
                    if (mHits % 4 == 0 && mVel < 6) mVel++;
`endif
                end else begin
                    ny = mY + mVel;
                    if (ny >= 472) begin ny = 472; missed = 1; mState = 2; mCnt = 0; end
                end
                mX = nx;
                mY = ny;
            end
            default: begin
                mCnt++;
                if (mCnt == 60) begin
                    mCnt = 0; mState = 0; mVel = 2; mHits = 0;
                end
            end
        endcase
        ePulse = (int'(padHit) << 2) | (int'(wall) << 1) | int'(missed);
    endtask

    task automatic checkFrame();
        checkOutput($sformatf("state@%0d", frameNo), state, mState);
        checkOutput($sformatf("ballX@%0d", frameNo), ballX, mX);
        checkOutput($sformatf("ballY@%0d", frameNo), ballY, mY);
        checkOutput($sformatf("active@%0d", frameNo), ballActive, int'(mState == 1));
        checkOutput($sformatf("pulses@%0d", frameNo), {paddleHit, wallHit, miss}, ePulse);
    endtask

    // One frame: optional launch pulse, then the frame-tick pixel position held for four clocks.
    task automatic applyStimulus(input int pad, input bit doLaunch);
        if (doLaunch) begin
            @(negedge clock); launch = 1'b1;
            if (mState == 0) mPend = 1;
            @(negedge clock); launch = 1'b0;
        end
        @(negedge clock);
        paddleX = 10'(pad);
        pixelY  = 10'd481;
        pixelX  = 10'd0;
        modelStep(pad);
        frameNo++;
        @(negedge clock);
        checkFrame();
        @(negedge clock);
        checkOutput($sformatf("pulseClear@%0d", frameNo), {paddleHit, wallHit, miss}, 0);
        @(negedge clock);
        @(negedge clock);
        pixelX = 10'($urandom_range(1, 639));
        @(negedge clock);
        pixelY = 10'($urandom_range(0, 480));
        pixelX = 10'd0;
    endtask

    function automatic int pickPaddle();
        int p;
        if (mState == 1 && $urandom_range(0, 3) != 0)
            p = mX + 4 - int'($urandom_range(0, 66));
        else
            p = int'($urandom_range(0, 576));
        if (p < 0)   p = 0;
        if (p > 576) p = 576;
        return p;
    endfunction

    initial begin
        bit sawMiss;
        modelReset();
        repeat (2) @(negedge clock);
        checkOutput("resetState", state, 0);
        checkOutput("resetX", ballX, 316);
        checkOutput("resetY", ballY, 442);
        checkOutput("resetPulses", {paddleHit, wallHit, miss, ballActive}, 0);
        @(negedge clock); reset = 1'b1;

        applyStimulus(100, 0);
        applyStimulus(100, 0);
        applyStimulus(100, 1);
        applyStimulus(100, 0);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus(pickPaddle(), (mState != 1) ? ($urandom_range(0, 3) == 0)
                                                      : ($urandom_range(0, 15) == 0));
        end

        // Drive into MISS, then reset asynchronously between clock edges.
        sawMiss = 0;
        for (int i = 0; i < 800 && !sawMiss; i++) begin
            applyStimulus(mState == 0 ? 300 : 0, mState == 0);
            if (mState == 2) sawMiss = 1;
        end
        checkOutput("reachMiss", int'(sawMiss), 1);
        applyStimulus(200, 1);
        applyStimulus(200, 0);
        @(negedge clock);
        pixelY = 10'd0;
        #2 reset = 1'b0;
        #1;
        checkOutput("asyncResetState", state, 0);
        checkOutput("asyncResetX", ballX, 316);
        checkOutput("asyncResetY", ballY, 442);
        @(negedge clock); reset = 1'b1;
        modelReset();
        applyStimulus(100, 0);
        applyStimulus(100, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
